// File: rtl/sensors_accumulator.sv
// Sequential sensor summing block: snapshot, per-channel scan, restoring divide, valid/ready result.
// Optional min/max tracking is enabled by defining SENSORS_MIN_MAX_EN.
`timescale 1ns/1ps
module sensors_accumulator #(
   parameter int NR_SENSORS = 5,
   parameter int DATA_WIDTH = 8,
   parameter int SUM_WIDTH  = 16,
   parameter int CNT_WIDTH  = 8
) (
   input  logic                             clk_i,
   input  logic                             rst_i,
   input  logic                             start_i,
   input  logic [NR_SENSORS*DATA_WIDTH-1:0] sensors_data_i,
   input  logic [NR_SENSORS-1:0]            sensors_en_i,
   output logic                             busy_o,
   output logic                             valid_o,
   input  logic                             ready_i,
   output logic [SUM_WIDTH-1:0]             temp_sum_o,
   output logic [CNT_WIDTH-1:0]             nr_active_sensors_o,
   output logic [DATA_WIDTH-1:0]            temp_avg_o,
`ifdef SENSORS_MIN_MAX_EN
   output logic [DATA_WIDTH-1:0]            temp_min_o,
   output logic [DATA_WIDTH-1:0]            temp_max_o,
`endif
   output logic                             no_sensor_o
);

   localparam int IDX_W = $clog2(NR_SENSORS + 1);
   localparam int BIT_W = $clog2(SUM_WIDTH);
   localparam logic [IDX_W-1:0] DECIDE_IDX = IDX_W'(NR_SENSORS);
   localparam logic [BIT_W-1:0] LAST_BIT   = BIT_W'(SUM_WIDTH - 1);

   typedef enum logic [1:0] {S_IDLE, S_SCAN, S_DIVIDE, S_DONE} state_t;

   state_t                           r_state;
   logic [NR_SENSORS*DATA_WIDTH-1:0] r_data;
   logic [NR_SENSORS-1:0]            r_en;
   logic [IDX_W-1:0]                 r_idx;
   logic [SUM_WIDTH-1:0]             r_sum;
   logic [CNT_WIDTH-1:0]             r_cnt;
   logic [SUM_WIDTH-1:0]             r_rem;
   logic [SUM_WIDTH-1:0]             r_quo;
   logic [BIT_W-1:0]                 r_bit;
   logic                             r_valid;
   logic [SUM_WIDTH-1:0]             r_sum_out;
   logic [CNT_WIDTH-1:0]             r_cnt_out;
   logic [DATA_WIDTH-1:0]            r_avg_out;
   logic                             r_nos_out;
`ifdef SENSORS_MIN_MAX_EN
   logic [DATA_WIDTH-1:0]            r_min;
   logic [DATA_WIDTH-1:0]            r_max;
   logic [DATA_WIDTH-1:0]            r_min_out;
   logic [DATA_WIDTH-1:0]            r_max_out;
`endif

   logic [DATA_WIDTH-1:0] w_sample;
   logic                  w_hit;
   logic                  w_capture;
   logic [SUM_WIDTH:0]    w_shift;
   logic [SUM_WIDTH:0]    w_div;
   logic                  w_ge;
   logic [SUM_WIDTH-1:0]  w_diff;
   logic [SUM_WIDTH-1:0]  w_rem_nxt;
   logic [SUM_WIDTH-1:0]  w_quo_nxt;

   always_comb begin
      w_sample = '0;
      w_hit    = 1'b0;
      for (int k = 0; k < NR_SENSORS; k++) begin
         if (r_idx == IDX_W'(k)) begin
            w_sample = r_data[k*DATA_WIDTH +: DATA_WIDTH];
            w_hit    = r_en[k];
         end
      end
   end

   // A new measurement can also be launched in the handshake cycle of the previous one.
   assign w_capture = start_i && ((r_state == S_IDLE) || ((r_state == S_DONE) && ready_i));

   // Remainder stays below the divisor, so a SUM_WIDTH-bit difference is exact whenever w_ge holds.
   assign w_shift   = {r_rem, r_quo[SUM_WIDTH-1]};
   assign w_div     = {1'b0, SUM_WIDTH'(r_cnt)};
   assign w_ge      = (w_shift >= w_div);
   assign w_diff    = w_shift[SUM_WIDTH-1:0] - w_div[SUM_WIDTH-1:0];
   assign w_rem_nxt = w_ge ? w_diff : w_shift[SUM_WIDTH-1:0];
   assign w_quo_nxt = {r_quo[SUM_WIDTH-2:0], w_ge};

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_state   <= S_IDLE;
         r_data    <= '0;
         r_en      <= '0;
         r_idx     <= '0;
         r_sum     <= '0;
         r_cnt     <= '0;
         r_rem     <= '0;
         r_quo     <= '0;
         r_bit     <= '0;
         r_valid   <= 1'b0;
         r_sum_out <= '0;
         r_cnt_out <= '0;
         r_avg_out <= '0;
         r_nos_out <= 1'b0;
`ifdef SENSORS_MIN_MAX_EN
         r_min     <= '0;
         r_max     <= '0;
         r_min_out <= '0;
         r_max_out <= '0;
`endif
      end else begin
         case (r_state)
            S_SCAN: begin
               if (r_idx == DECIDE_IDX) begin
                  if (r_cnt == '0) begin
                     r_sum_out <= r_sum;
                     r_cnt_out <= r_cnt;
                     r_avg_out <= '0;
                     r_nos_out <= 1'b1;
`ifdef SENSORS_MIN_MAX_EN
                     r_min_out <= '0;
                     r_max_out <= '0;
`endif
                     r_valid   <= 1'b1;
                     r_state   <= S_DONE;
                  end else begin
                     r_rem   <= '0;
                     r_quo   <= r_sum;
                     r_bit   <= '0;
                     r_state <= S_DIVIDE;
                  end
               end else begin
                  if (w_hit) begin
                     r_sum <= r_sum + {{(SUM_WIDTH-DATA_WIDTH){1'b0}}, w_sample};
                     r_cnt <= r_cnt + CNT_WIDTH'(1);
`ifdef SENSORS_MIN_MAX_EN
                     if (w_sample < r_min) r_min <= w_sample;
                     if (w_sample > r_max) r_max <= w_sample;
`endif
                  end
                  r_idx <= r_idx + IDX_W'(1);
               end
            end
            S_DIVIDE: begin
               r_rem <= w_rem_nxt;
               r_quo <= w_quo_nxt;
               r_bit <= r_bit + BIT_W'(1);
               if (r_bit == LAST_BIT) begin
                  r_sum_out <= r_sum;
                  r_cnt_out <= r_cnt;
                  r_avg_out <= w_quo_nxt[DATA_WIDTH-1:0];
                  r_nos_out <= 1'b0;
`ifdef SENSORS_MIN_MAX_EN
                  r_min_out <= r_min;
                  r_max_out <= r_max;
`endif
                  r_valid   <= 1'b1;
                  r_state   <= S_DONE;
               end
            end
            S_DONE: begin
               if (ready_i) begin
                  r_valid <= 1'b0;
                  if (!start_i) r_state <= S_IDLE;
               end
            end
            default: ;
         endcase

         if (w_capture) begin
            r_data  <= sensors_data_i;
            r_en    <= sensors_en_i;
            r_idx   <= '0;
            r_sum   <= '0;
            r_cnt   <= '0;
`ifdef SENSORS_MIN_MAX_EN
            r_min   <= '1;
            r_max   <= '0;
`endif
            r_state <= S_SCAN;
         end
      end
   end

   assign busy_o              = (r_state != S_IDLE);
   assign valid_o             = r_valid;
   assign temp_sum_o          = r_sum_out;
   assign nr_active_sensors_o = r_cnt_out;
   assign temp_avg_o          = r_avg_out;
   assign no_sensor_o         = r_nos_out;
`ifdef SENSORS_MIN_MAX_EN
   assign temp_min_o          = r_min_out;
   assign temp_max_o          = r_max_out;
`endif

endmodule

// File: tb/tb_sensors_accumulator.sv
// Scoreboard bench for sensors_accumulator: driver queues expected results, negedge monitor checks them.
`timescale 1ns/1ps
module tb_sensors_accumulator;

   localparam int N  = 5;
   localparam int DW = 8;
   localparam int SW = 16;
   localparam int CW = 8;

   logic            clk = 1'b0;
   logic            rst_i, start_i, ready_i;
   logic [N*DW-1:0] data_i;
   logic [N-1:0]    en_i;
   logic            busy_o, valid_o, no_sensor_o;
   logic [SW-1:0]   temp_sum_o;
   logic [CW-1:0]   nr_active_sensors_o;
   logic [DW-1:0]   temp_avg_o;
`ifdef SENSORS_MIN_MAX_EN
   logic [DW-1:0]   temp_min_o, temp_max_o;
`endif

   sensors_accumulator #(.NR_SENSORS(N), .DATA_WIDTH(DW), .SUM_WIDTH(SW), .CNT_WIDTH(CW)) dut (
      .clk_i(clk), .rst_i(rst_i), .start_i(start_i),
      .sensors_data_i(data_i), .sensors_en_i(en_i),
      .busy_o(busy_o), .valid_o(valid_o), .ready_i(ready_i),
      .temp_sum_o(temp_sum_o), .nr_active_sensors_o(nr_active_sensors_o),
      .temp_avg_o(temp_avg_o),
`ifdef SENSORS_MIN_MAX_EN
      .temp_min_o(temp_min_o), .temp_max_o(temp_max_o),
`endif
      .no_sensor_o(no_sensor_o)
   );

   always #5 clk = ~clk;

   typedef struct {
      int sum;
      int cnt;
      int avg;
      int nos;
      int mn;
      int mx;
   } exp_t;

   exp_t exp_q[$];
   int   n_chk  = 0;
   int   n_pass = 0;

   task automatic chk(input string nm, input longint act, input longint exp);
      n_chk++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
   endtask

   function automatic exp_t mk(input int s, input int c, input int a, input int z,
                               input int mn, input int mx);
      exp_t x;
      x.sum = s; x.cnt = c; x.avg = a; x.nos = z; x.mn = mn; x.mx = mx;
      return x;
   endfunction

   function automatic logic [N*DW-1:0] pack(input int c4, input int c3, input int c2,
                                            input int c1, input int c0);
      return {DW'(c4), DW'(c3), DW'(c2), DW'(c1), DW'(c0)};
   endfunction

   // Monitor: every cycle a result is presented it must match the head of the queue.
   always @(negedge clk) begin
      if (valid_o === 1'b1) begin
         if (exp_q.size() == 0) chk("unexpected_valid", 1, 0);
         else begin
            chk("sum", temp_sum_o, exp_q[0].sum);
            chk("count", nr_active_sensors_o, exp_q[0].cnt);
            chk("avg", temp_avg_o, exp_q[0].avg);
            chk("no_sensor", no_sensor_o, exp_q[0].nos);
`ifdef SENSORS_MIN_MAX_EN
            chk("min", temp_min_o, exp_q[0].mn);
            chk("max", temp_max_o, exp_q[0].mx);
`endif
            if (ready_i) void'(exp_q.pop_front());
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic scramble();
      data_i = N*DW'({$urandom(), $urandom()});
      en_i   = N'($urandom());
   endtask

   task automatic wait_valid(input int exp_lat, input string nm);
      int lat = 0;
      while (valid_o !== 1'b1 && lat < 100) begin
         tick();
         lat++;
      end
      chk(nm, lat, exp_lat);
   endtask

   task automatic run(input logic [N*DW-1:0] d, input logic [N-1:0] e, input exp_t x,
                      input int lat, input string nm);
      data_i  = d;
      en_i    = e;
      start_i = 1'b1;
      exp_q.push_back(x);
      tick();
      start_i = 1'b0;
      scramble();
      wait_valid(lat, nm);
      tick();
      chk({nm, "_valid_fall"}, valid_o, 0);
      chk({nm, "_idle"}, busy_o, 0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      rst_i   = 1'b1;
      start_i = 1'b0;
      ready_i = 1'b1;
      scramble();
      repeat (2) begin
         start_i = 1'($urandom());
         ready_i = 1'($urandom());
         scramble();
         tick();
      end
      chk("rst_busy", busy_o, 0);
      chk("rst_valid", valid_o, 0);
      chk("rst_sum", temp_sum_o, 0);
      chk("rst_count", nr_active_sensors_o, 0);
      chk("rst_avg", temp_avg_o, 0);
      chk("rst_no_sensor", no_sensor_o, 0);
`ifdef SENSORS_MIN_MAX_EN
      chk("rst_min", temp_min_o, 0);
      chk("rst_max", temp_max_o, 0);
`endif
      rst_i   = 1'b0;
      start_i = 1'b0;
      ready_i = 1'b1;
      tick();

      run(pack(50, 40, 30, 20, 10), 5'b11111, mk(150, 5, 30, 0, 10, 50), 22, "lat_all");
      run(pack(33, 200, 8, 99, 7), 5'b00101, mk(15, 2, 7, 0, 7, 8), 22, "lat_partial");
      run(pack(255, 255, 255, 255, 255), 5'b11111, mk(1275, 5, 255, 0, 255, 255), 22, "lat_max");
      run(pack(1, 2, 3, 4, 5), 5'b00000, mk(0, 0, 0, 1, 0, 0), 6, "lat_none");
      run(pack(200, 0, 0, 0, 0), 5'b10000, mk(200, 1, 200, 0, 200, 200), 22, "lat_single");
      run(pack(0, 0, 2, 2, 1), 5'b00111, mk(5, 3, 1, 0, 1, 2), 22, "lat_trunc");

      // Backpressure: result must hold while ready_i is low, start ignored.
      ready_i = 1'b0;
      data_i  = pack(100, 40, 30, 20, 10);
      en_i    = 5'b11111;
      start_i = 1'b1;
      exp_q.push_back(mk(200, 5, 40, 0, 10, 100));
      tick();
      start_i = 1'b0;
      wait_valid(22, "lat_bp");
      repeat (10) begin
         scramble();
         start_i = ~start_i;
         tick();
      end
      chk("bp_valid_held", valid_o, 1);
      chk("bp_busy_held", busy_o, 1);

      // Handshake with start in the same cycle: straight back to SCAN.
      data_i  = pack(0, 51, 0, 100, 0);
      en_i    = 5'b01010;
      ready_i = 1'b1;
      start_i = 1'b1;
      exp_q.push_back(mk(151, 2, 75, 0, 51, 100));
      tick();
      start_i = 1'b0;
      scramble();
      chk("b2b_busy", busy_o, 1);
      chk("b2b_valid", valid_o, 0);
      wait_valid(22, "lat_b2b");
      tick();
      chk("b2b_idle", busy_o, 0);

      // Reset in the fifth DIVIDE cycle aborts the operation.
      data_i  = pack(50, 40, 30, 20, 10);
      en_i    = 5'b11111;
      start_i = 1'b1;
      tick();
      start_i = 1'b0;
      repeat (10) tick();
      chk("mid_busy", busy_o, 1);
      rst_i = 1'b1;
      tick();
      rst_i = 1'b0;
      chk("mid_rst_busy", busy_o, 0);
      chk("mid_rst_valid", valid_o, 0);
      chk("mid_rst_sum", temp_sum_o, 0);
      chk("mid_rst_count", nr_active_sensors_o, 0);
      chk("mid_rst_avg", temp_avg_o, 0);
      repeat (25) tick();
      chk("mid_no_valid", valid_o, 0);

      run(pack(50, 40, 30, 20, 10), 5'b11111, mk(150, 5, 30, 0, 10, 50), 22, "lat_recover");

      repeat (3) tick();
      chk("queue_drained", exp_q.size(), 0);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule

// File: doc/sensors_accumulator.md
Name: sensors_accumulator

Overview:
- Parametrised, sequential successor to the team's combinational sensor summing block.
- Snapshots NR_SENSORS enabled temperature channels on a start request, then scans them one per cycle to form the sum and active count.
- Computes the truncated average with an iterative restoring divider.
- Presents the result on a valid/ready handshake to the downstream temperature-monitoring control logic.

Parameters:
- NR_SENSORS, 5: number of sensor channels, minimum 1.
- DATA_WIDTH, 8: width of each unsigned sensor sample.
- SUM_WIDTH, 16: accumulator width; must satisfy SUM_WIDTH >= DATA_WIDTH + clog2(NR_SENSORS+1).
- CNT_WIDTH, 8: active-sensor counter width; must satisfy CNT_WIDTH >= clog2(NR_SENSORS+1).

Ports:
- clk_i, input, 1: clock, rising edge.
- rst_i, input, 1: synchronous active-high reset.
- start_i, input, 1: request a new measurement.
- sensors_data_i, input, NR_SENSORS*DATA_WIDTH: channel k occupies bits [k*DATA_WIDTH +: DATA_WIDTH].
- sensors_en_i, input, NR_SENSORS: per-channel enable.
- busy_o, output, 1: FSM is not in IDLE.
- valid_o, output, 1: result available.
- ready_i, input, 1: downstream accepts the result.
- temp_sum_o, output, SUM_WIDTH: sum of enabled samples.
- nr_active_sensors_o, output, CNT_WIDTH: number of enabled channels.
- temp_avg_o, output, DATA_WIDTH: floor(sum/count).
- no_sensor_o, output, 1: result was produced with zero channels enabled.

Behaviour:
- Interface: one clock; reset is synchronous and active-high.
- Reset: FSM goes to IDLE. All outputs are 0: busy_o, valid_o, temp_sum_o, nr_active_sensors_o, temp_avg_o, no_sensor_o. Internal snapshot, accumulator and divider registers are cleared.
- rst_i has priority over every other event, including mid-SCAN and mid-DIVIDE. The operation is discarded and no valid_o is produced.
- FSM states: IDLE, SCAN, DIVIDE, DONE.
- IDLE:
  - start_i=1 registers sensors_data_i and sensors_en_i into snapshot registers, clears sum/count/index, and moves to SCAN.
  - Input changes after the start cycle do not affect the result.
- SCAN:
  - One channel per cycle, index 0..NR_SENSORS-1 (exactly NR_SENSORS cycles).
  - If the snapshot enable[idx]=1: sum += zero-extended sample, count += 1.
  - After the last index: if count==0, go to DONE with avg=0 and no_sensor=1. Otherwise go to DIVIDE.
- DIVIDE:
  - Restoring division, one quotient bit per cycle, SUM_WIDTH cycles, MSB first. Divisor is count, zero-extended.
  - The quotient is truncated (floor) and always <= max sample, so the low DATA_WIDTH bits are exact.
  - Then go to DONE.
- DONE:
  - valid_o=1. temp_sum_o, nr_active_sensors_o, temp_avg_o and no_sensor_o are stable while valid_o=1 && ready_i=0.
  - On valid_o && ready_i, the transfer completes.
  - If start_i=1 in the same cycle, capture new inputs and go directly to SCAN (back-to-back). Otherwise go to IDLE.
- Result outputs update only on entry to DONE. They retain the last result after the handshake; valid_o falls.
- start_i is ignored in SCAN and DIVIDE. It is also ignored in DONE unless ready_i=1.
- busy_o=1 in SCAN, DIVIDE and DONE.
- Latency, with start_i sampled at edge 0:
  - count>0: valid_o rises after edge NR_SENSORS+SUM_WIDTH+1.
  - count==0: valid_o rises after edge NR_SENSORS+1.
  - Defaults: 22 and 6 cycles respectively.
- Arithmetic is unsigned throughout. No overflow is possible within the parameter constraints.

Optional Feature:
- Macro: SENSORS_MIN_MAX_EN.
- Defined:
  - Adds output ports temp_min_o and temp_max_o, each DATA_WIDTH wide. Both reset to 0.
  - Tracked during SCAN over enabled channels only.
  - Minimum is initialised to all-ones and maximum to 0 at start.
  - Published on entry to DONE with the other results. Both are 0 when count==0.
- Undefined: ports and tracking logic are absent. All other behaviour is identical.

Test Plan:
- Reset: assert rst_i 2 cycles with random inputs -> all outputs 0, busy_o=0, valid_o=0.
- All enabled: data {50,40,30,20,10} (ch4..ch0), en=5'b11111, start 1 cycle -> valid_o after 22 cycles. sum=150, count=5, avg=30, no_sensor=0. With the macro: min=10, max=50.
- Partial and truncation: ch0=7, ch2=8, en=5'b00101 -> sum=15, count=2, avg=7. Also all 255, en=all -> sum=1275, avg=255.
- No sensors: en=0 -> valid_o after 6 cycles, sum=0, count=0, avg=0, no_sensor_o=1.
- Backpressure:
  - Hold ready_i=0 for 10 cycles after valid, toggle data/en and pulse start_i -> outputs stable, no restart.
  - Then ready_i=1 with start_i=1 -> next result (new inputs) arrives with no IDLE cycle.
- Mid-operation reset: assert rst_i in DIVIDE cycle 5 -> IDLE next cycle, outputs 0, no valid_o. A subsequent start yields a correct result.
